// File: rtl/usb_pkg.sv
// Shared definitions for the USB receive path (rcv_block, rx data buffer, host-side controller).
package usb_pkg;

  localparam int BUFFER_DEPTH = 64;
  localparam int OCC_W = $clog2(BUFFER_DEPTH) + 1;

  typedef enum logic [1:0] {
    READ_1    = 2'd0,
    READ_2    = 2'd1,
    READ_4    = 2'd2,
    READ_RSVD = 2'd3
  } rx_read_size_t;

  // Number of bytes a read request consumes; zero marks the reserved encoding.
  function automatic logic [2:0] read_bytes(input rx_read_size_t size);
    case (size)
      READ_1:  read_bytes = 3'd1;
      READ_2:  read_bytes = 3'd2;
      READ_4:  read_bytes = 3'd4;
      default: read_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/usb_buffer_mem.sv
// DEPTH x 8 register file with one write port and four combinational read taps
// at consecutive addresses starting at rd_addr (wrapping modulo DEPTH).
module usb_buffer_mem
  import usb_pkg::*;
#(
  parameter int DEPTH = BUFFER_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [7:0]      wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [3:0][7:0] taps
);

  logic [7:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_tap
    logic [AW-1:0] tap_addr;
    assign tap_addr = rd_addr + AW'(i);
    assign taps[i]  = mem[tap_addr];
  end

endmodule

// File: rtl/usb_rx_data_buffer.sv
// Receive-side byte FIFO between rcv_block and the host side; drains in 1/2/4-byte
// little-endian reads and reports occupancy back to the receiver.
module usb_rx_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH = BUFFER_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int OW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          clear,
  input  logic          w_enable,
  input  logic [7:0]    rcv_data,
  input  logic          r_enable,
  input  logic [1:0]    r_size,
  output logic [31:0]   rx_data,
  output logic [OW-1:0] buffer_occupancy,
  output logic          overrun,
  output logic          underrun
);

  // w_enable and r_enable are single-cycle requests with no ready/backpressure:
  // each is either taken on the sampling edge or refused, and a refusal is reported
  // one cycle later on overrun / underrun. Occupancy shows the result of every edge.

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [OW-1:0]   occ;
  logic [3:0][7:0] taps;

  rx_read_size_t size;
  logic [2:0]    n_bytes;
  logic [OW-1:0] n_ext;
  logic          purge;
  logic          rd_valid;
  logic          wr_accept;
  logic [31:0]   rd_word;
  logic [OW-1:0] occ_next;

  assign size    = rx_read_size_t'(r_size);
  assign n_bytes = read_bytes(size);
  assign n_ext   = OW'(n_bytes);
  assign purge   = flush | clear;

  // Decisions use start-of-cycle occupancy, so a same-cycle write is never readable.
  assign rd_valid  = r_enable && (size != READ_RSVD) && (n_ext <= occ);
  assign wr_accept = w_enable && ((occ < OW'(DEPTH)) || rd_valid);

  assign occ_next = occ + OW'(wr_accept) - (rd_valid ? n_ext : '0);

  always_comb begin
    rd_word = 32'h0;
    case (size)
      READ_1:  rd_word = {24'h0, taps[0]};
      READ_2:  rd_word = {16'h0, taps[1], taps[0]};
      default: rd_word = {taps[3], taps[2], taps[1], taps[0]};
    endcase
  end

  usb_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept && !purge),
    .wr_addr (wr_ptr),
    .wr_data (rcv_data),
    .rd_addr (rd_ptr),
    .taps    (taps)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      rx_data  <= 32'h0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else if (purge) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      rx_data  <= 32'h0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_valid) begin
        rd_ptr  <= rd_ptr + AW'(n_bytes);
        rx_data <= rd_word;
      end
      occ      <= occ_next;
      overrun  <= w_enable && !wr_accept;
      underrun <= r_enable && !rd_valid;
    end
  end

  assign buffer_occupancy = occ;

endmodule

// File: doc/usb_rx_data_buffer.md
# usb_rx_data_buffer

Receive-side packet data buffer directly downstream of `rcv_block`. It captures each byte written by the receiver (`w_enable`/`rcv_data`) into a 64-entry FIFO and reports occupancy back to the receiver on `buffer_occupancy`. It honours the receiver's `flush`. The protocol/host side drains it in 1-, 2- or 4-byte reads.

## Interface
- `DEPTH`, 64, byte capacity; power of two; occupancy width is clog2(DEPTH)+1.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  from rcv_block; empties buffer.
- `clear`  in  1  from host side; identical effect to `flush`.
- `w_enable`  in  1  from rcv_block; write `rcv_data` this cycle.
- `rcv_data`  in  8  byte from rcv_block.
- `r_enable`  in  1  read request.
- `r_size`  in  2  read size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = reserved.
- `rx_data`  out  32  read result. Little-endian: oldest byte in [7:0]. Unread upper bytes are zero.
- `buffer_occupancy`  out  7  bytes currently stored, 0..64.
- `overrun`  out  1  one-cycle pulse: a write was dropped.
- `underrun`  out  1  one-cycle pulse: a read was rejected.

## Operation
- Storage is DEPTH x 8 registers.
- 6-bit `wr_ptr` and `rd_ptr` wrap modulo 64.
- A separate 7-bit occupancy counter drives `buffer_occupancy` directly.
- **Read size:** n = 1, 2 or 4 from `r_size`. `r_size = 3` is treated as a rejected read.
- **Valid read:**
  - Condition: `r_enable` and n <= occupancy at start of cycle.
  - Action: `rx_data` latches bytes `rd_ptr` .. `rd_ptr+n-1` (modulo 64) and `rd_ptr` advances by n.
- **Rejected read:**
  - Pointer and `rx_data` unchanged.
  - `underrun` pulses.
- **Write acceptance:** a write is accepted when `w_enable` and either:
  - occupancy < 64 at start of cycle, or
  - a valid read occurs in the same cycle.
- **Accepted write:** stores at `wr_ptr` and increments `wr_ptr`.
- **Dropped write:** `overrun` pulses and nothing is stored.
- **Occupancy update:** occupancy_next = occupancy + accepted_write − (valid read ? n : 0).
- **Same-cycle write and read:** the read sees only bytes present before the cycle. A byte written in cycle k is readable from cycle k+1. A read on an empty buffer with a simultaneous write is rejected (underrun).
- **Priority:** `flush` or `clear` overrides everything in that cycle. Effects:
  - pointers and occupancy go to 0;
  - `rx_data` goes to 0;
  - any same-cycle write or read is discarded;
  - no `overrun`/`underrun` pulse.
- **No flush/clear state machine:** the block is a pure datapath with pointer/counter state. The buffer holds data indefinitely until it is read or flushed.

## Timing
- **Reset values** (async `rst` high): `rx_data` = 0, `buffer_occupancy` = 0, `overrun` = 0, `underrun` = 0, both pointers = 0. Memory contents are don't-care.
- **Write to occupancy:** `buffer_occupancy` reflects a write on the edge that accepts it (1-cycle latency). rcv_block sees the new count the next cycle.
- **Read latency:**
  - `rx_data` is registered and valid the cycle after `r_enable` is sampled.
  - `rx_data` holds until the next valid read, flush, clear or reset.
- **Error pulses:** `overrun` and `underrun` are registered and high for exactly one cycle after the offending request.
- **Throughput:**
  - Back-to-back writes are accepted every cycle while not full.
  - Back-to-back reads are accepted every cycle while data suffices.
- **Reset mid-packet:** all state is lost immediately and asynchronously. The first write after `rst` deasserts lands at index 0.

## Structure
- **Shared package `usb_pkg`:**
  - `BUFFER_DEPTH` = 64;
  - enum `rx_read_size_t` {`READ_1`, `READ_2`, `READ_4`, `READ_RSVD`};
  - `OCC_W` = 7.
  - rcv_block and the host-side controller import the same package.
- **Sub-module `usb_buffer_mem`:**
  - DEPTH x 8 register file;
  - one write port;
  - four combinational read taps at `rd_ptr+0..3` (modulo 64).
- **Top level** holds the pointers, occupancy counter, acceptance logic and output registers.

## Test plan
- **Reset:** assert `rst` mid-operation with occupancy 10 -> all outputs 0 immediately. Writing 0xA5 afterwards, then a 1-byte read -> `rx_data` = 0x000000A5.
- **Little-endian multi-byte read:** write 0x11, 0x22, 0x33, 0x44, then `r_size` = 2 -> `rx_data` = 0x44332211, occupancy 4 -> 0.
- **Full and overrun:**
  - Write 64 bytes 0x00..0x3F -> occupancy 64.
  - A 65th write -> `overrun` pulses one cycle and occupancy stays 64.
  - Write plus 1-byte read in the same cycle -> occupancy stays 64, `rx_data` = 0x00, new byte stored.
- **Wrap-around:** fill to 62, read 60, write 8, read 4 bytes twice -> returns bytes 60..63 then 64..67 in order across the index wrap.
- **Underrun:**
  - With occupancy 3, `r_size` = 2 -> `underrun` pulses and `rx_data` and occupancy are unchanged.
  - `r_size` = 3 -> also `underrun`.
  - Empty buffer with simultaneous write and 1-byte read -> `underrun`, occupancy becomes 1.
- **Flush priority:** with occupancy 25, `flush` together with `w_enable` and `r_enable` -> occupancy 0, `rx_data` 0, no pulses. Repeat with `clear`.
